// File: rtl/echo_mixer_if.sv
// Sample and control bundle between the delay-line front end and echo_mixer.
// The master side drives samples and controls; the slave (the mixer) returns the mixed output.
interface echo_mixer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dry;
  logic [WIDTH-1:0] wet;
  logic             enable;
  logic [1:0]       mode;
  logic [1:0]       wet_shift;
  logic             clear_ovf;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             overflow;
  logic [WIDTH-1:0] peak;

  modport master (
    output dry, wet, enable, mode, wet_shift, clear_ovf,
    input  out, valid, overflow, peak
  );

  modport slave (
    input  dry, wet, enable, mode, wet_shift, clear_ovf,
    output out, valid, overflow, peak
  );
endinterface

// File: rtl/echo_mixer.sv
// Dry/wet echo mixer. The output stays invalid until the delay line has flushed its reset contents.
// Define ECHO_MIXER_PEAK_EN to add a running-peak register on bus.peak; otherwise peak is tied to 0.
module echo_mixer #(
  parameter int WIDTH       = 8,
  parameter int FILL_CYCLES = 60
) (
  input logic         clock,
  input logic         reset_n,
  echo_mixer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [7:0] LAST_FILL = 8'(FILL_CYCLES - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] out_q;
  logic             valid_q;
  logic             overflow_q;

  logic [WIDTH:0]   echo_sum;
  logic [WIDTH:0]   avg_sum;
  logic [WIDTH-1:0] mixed;
  logic             saturate;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    echo_sum = {1'b0, bus.dry} + ({1'b0, bus.wet} >> bus.wet_shift);
    avg_sum  = {1'b0, bus.dry} + {1'b0, bus.wet} + (WIDTH + 1)'(1);
    saturate = 1'b0;
    mixed    = '0;
    case (bus.mode)
      2'b00: mixed = bus.dry;
      2'b01: mixed = bus.wet;
      2'b10: begin
        saturate = echo_sum[WIDTH];
        mixed    = echo_sum[WIDTH] ? '1 : echo_sum[WIDTH-1:0];
      end
      default: mixed = avg_sum[WIDTH:1];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_q   <= '0;
          valid_q <= 1'b0;
          if (bus.enable) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        FILL: begin
          // wet still carries post-reset contents, so only dry is passed through
          out_q   <= bus.dry;
          valid_q <= 1'b0;
          if (!bus.enable)            state <= IDLE;
          else if (cnt == LAST_FILL)  state <= RUN;
          else                        cnt   <= cnt + 8'd1;
        end
        RUN: begin
          out_q   <= mixed;
          valid_q <= 1'b1;
          if (!bus.enable) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          out_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase

      // a saturation event on the same edge as a clear keeps the flag set
      if (state == RUN && saturate) overflow_q <= 1'b1;
      else if (bus.clear_ovf)       overflow_q <= 1'b0;
    end
  end

  assign bus.out      = out_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;

`ifdef ECHO_MIXER_PEAK_EN
  logic [WIDTH-1:0] peak_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else if (bus.clear_ovf) begin
      peak_q <= (state == RUN) ? mixed : '0;
    end else if (state == RUN && mixed > peak_q) begin
      peak_q <= mixed;
    end
  end

  assign bus.peak = peak_q;
`else
  assign bus.peak = '0;
`endif
endmodule

// File: tb/tb_echo_mixer.sv
// Directed self-checking bench for echo_mixer: fill timing, mix modes, overflow, enable glitch, reset, peak.
module tb_echo_mixer;
  localparam int WIDTH = 8;
  localparam int FC    = 60;
`ifdef ECHO_MIXER_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  echo_mixer_if #(.WIDTH(WIDTH)) bus ();

  echo_mixer #(.WIDTH(WIDTH), .FILL_CYCLES(FC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] peak_exp(input logic [7:0] v);
    return PEAK_EN ? v : 8'h00;
  endfunction

  initial begin
    reset_n       = 1'b0;
    bus.enable    = 1'b0;
    bus.dry       = 8'h00;
    bus.wet       = 8'h00;
    bus.mode      = 2'b00;
    bus.wet_shift = 2'b00;
    bus.clear_ovf = 1'b0;

    // reset state
    repeat (3) step();
    check("reset_out", bus.out, 8'h00);
    check("reset_valid", bus.valid, 1'b0);
    check("reset_overflow", bus.overflow, 1'b0);
    check("reset_peak", bus.peak, 8'h00);

    reset_n = 1'b1;
    step();
    check("idle_after_release", {bus.valid, bus.out}, 9'h000);

    // initial fill: enable sampled at E0
    bus.enable = 1'b1;
    bus.dry    = 8'h11;
    bus.wet    = 8'h22;
    bus.mode   = 2'b01;
    step();
    check("e0_idle_output", {bus.valid, bus.out}, 9'h000);
    for (int i = 1; i <= FC; i++) begin
      step();
      check("fill_passthrough", {bus.valid, bus.out}, {1'b0, 8'h11});
    end
    step();
    check("first_valid_wet", {bus.valid, bus.out}, {1'b1, 8'h22});

    // echo sum with saturation
    bus.mode = 2'b10; bus.dry = 8'hF0; bus.wet = 8'h40; bus.wet_shift = 2'd0;
    step();
    check("echo_sat_out", bus.out, 8'hFF);
    check("echo_sat_ovf", bus.overflow, 1'b1);
    bus.wet_shift = 2'd3;
    step();
    check("echo_shift3_out", bus.out, 8'hF8);
    check("echo_shift3_ovf_sticky", bus.overflow, 1'b1);
    bus.clear_ovf = 1'b1;
    step();
    bus.clear_ovf = 1'b0;
    check("clear_ovf", bus.overflow, 1'b0);

    // average rounding
    bus.mode = 2'b11; bus.dry = 8'h03; bus.wet = 8'h04;
    step();
    check("avg_round_up", bus.out, 8'h04);
    bus.dry = 8'hFF; bus.wet = 8'hFF;
    step();
    check("avg_max", bus.out, 8'hFF);
    check("avg_no_ovf", bus.overflow, 1'b0);

    // set/clear collision: set wins
    bus.mode = 2'b10; bus.dry = 8'hF0; bus.wet = 8'h40; bus.wet_shift = 2'd0;
    bus.clear_ovf = 1'b1;
    step();
    check("collision_set_wins", bus.overflow, 1'b1);
    bus.mode = 2'b00;
    step();
    bus.clear_ovf = 1'b0;
    check("collision_then_clear", bus.overflow, 1'b0);

    // peak: clear lands with 0x10, then 0x80, 0x20, then clear with 0x30
    bus.mode = 2'b00; bus.dry = 8'h10; bus.clear_ovf = 1'b1;
    step();
    bus.clear_ovf = 1'b0;
    check("peak_out_10", bus.out, 8'h10);
    check("peak_clear_with_sample", bus.peak, peak_exp(8'h10));
    bus.dry = 8'h80;
    step();
    check("peak_out_80", bus.out, 8'h80);
    check("peak_rise", bus.peak, peak_exp(8'h80));
    bus.mode = 2'b10; bus.dry = 8'h10; bus.wet = 8'h40; bus.wet_shift = 2'd2;
    step();
    check("echo_shift2_out", bus.out, 8'h20);
    check("peak_hold", bus.peak, peak_exp(8'h80));
    bus.wet_shift = 2'd1; bus.clear_ovf = 1'b1;
    step();
    bus.clear_ovf = 1'b0;
    check("echo_shift1_out", bus.out, 8'h30);
    check("peak_clear_reload", bus.peak, peak_exp(8'h30));

    // enable glitch: output from edge k still RUN, then IDLE, then full refill
    bus.mode = 2'b00; bus.dry = 8'h55; bus.enable = 1'b0;
    step();
    check("glitch_edge_k", {bus.valid, bus.out}, {1'b1, 8'h55});
    bus.enable = 1'b1;
    step();
    check("glitch_idle_cycle", {bus.valid, bus.out}, 9'h000);
    bus.mode = 2'b10; bus.dry = 8'hF0; bus.wet = 8'h40; bus.wet_shift = 2'd0;
    for (int i = 1; i <= FC; i++) begin
      step();
      check("refill_passthrough", {bus.overflow, bus.valid, bus.out}, {2'b00, 8'hF0});
    end
    step();
    check("refill_valid_sat", {bus.overflow, bus.valid, bus.out}, {2'b11, 8'hFF});

    // asynchronous reset mid-RUN
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.overflow, bus.valid, bus.out}, 10'h000);
    check("async_reset_peak", bus.peak, 8'h00);
    #2;
    reset_n = 1'b1;
    bus.mode = 2'b01; bus.wet = 8'h66; bus.dry = 8'h77;
    step();
    check("post_reset_e0", {bus.valid, bus.out}, 9'h000);
    repeat (FC) step();
    check("post_reset_fill_end", {bus.valid, bus.out}, {1'b0, 8'h77});
    step();
    check("post_reset_valid", {bus.valid, bus.out}, {1'b1, 8'h66});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/echo_mixer.md
# echo_mixer

Downstream consumer of the 8-bit sample delay line. Takes the undelayed (dry) sample and the delay line's output (wet) sample and produces one registered output sample per clock. A fill counter holds the output invalid until the delay line has flushed its post-reset contents. A mode input selects dry, wet, a scaled echo sum, or an average. A sticky flag records saturation events.

## Interface
Parameters:
- `WIDTH`, default 8: sample width in bits for dry, wet and out.
- `FILL_CYCLES`, default 60: upstream delay-line latency in clocks (30 stages × 2 registers); range 2..255.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset is asynchronous and active-low.
- `dry`, in, WIDTH: undelayed input sample (same sample fed to the delay line).
- `wet`, in, WIDTH: delay-line output sample.
- `enable`, in, 1: run request; low forces IDLE.
- `mode`, in, 2: 00 dry, 01 wet, 10 echo sum, 11 average.
- `wet_shift`, in, 2: right-shift applied to wet in echo-sum mode (gain 1, 1/2, 1/4, 1/8).
- `clear_ovf`, in, 1: synchronous clear of `overflow` (and `peak` when compiled in).
- `out`, out, WIDTH: registered mixed sample.
- `valid`, out, 1: high when `out` carries a RUN-state result.
- `overflow`, out, 1: sticky; set on echo-sum saturation.
- `peak`, out, WIDTH: running maximum of valid `out` (see Configuration).

## Operation
- FSM states: IDLE, FILL, RUN; 8-bit fill counter `cnt`.
- IDLE:
  - `enable` = 1 → FILL, `cnt` ← 0.
  - Otherwise stay in IDLE.
- FILL:
  - `enable` = 0 → IDLE.
  - `cnt` == FILL_CYCLES−1 → RUN.
  - Otherwise `cnt` ← `cnt` + 1.
- RUN:
  - `enable` = 0 → IDLE.
  - Otherwise stay in RUN.
- Dropping `enable` for one cycle always restarts the fill count from 0.
- Output register, computed from the pre-edge state:
  - IDLE: `out` ← 0, `valid` ← 0.
  - FILL: `out` ← `dry` (passthrough, since wet is untrusted), `valid` ← 0.
  - RUN: `out` ← f(`mode`), `valid` ← 1.
- f(`mode`), all arithmetic unsigned with a WIDTH+1 intermediate:
  - 00: `dry`.
  - 01: `wet`.
  - 10: `dry` + (`wet` >> `wet_shift`), saturated at 2^WIDTH−1.
  - 11: (`dry` + `wet` + 1) >> 1, i.e. rounded half up; cannot overflow.
- `overflow`:
  - Set when RUN, `mode` = 10 and the unsaturated sum exceeds 2^WIDTH−1.
  - Cleared by `clear_ovf`.
  - If set and clear occur on the same edge, set wins.
  - Not set in IDLE or FILL.
- `mode`, `wet_shift` and `dry`/`wet` are sampled every cycle with no handshake; a change takes effect on the next output.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, `cnt` = 0.
  - `out` = 0, `valid` = 0, `overflow` = 0, `peak` = 0.
- Release is synchronous to the next rising edge; no output changes on the release itself.
- Data latency in RUN: 1 clock from `dry`/`wet` sampled to `out`.
- With `enable` held high from edge E0, where IDLE→FILL occurs at E0:
  - RUN is entered at edge E0+FILL_CYCLES.
  - First `valid` = 1 appears after edge E0+FILL_CYCLES+1.
- `enable` falling sampled at edge k: `valid` = 0 and `out` = 0 after edge k+1. The output from edge k is still computed in RUN.
- Reset mid-RUN: all outputs clear immediately; a full fill is required again.

## Configuration
- Macro `ECHO_MIXER_PEAK_EN`.
- Defined:
  - `peak` ← max(`peak`, next `out`) on every edge that writes `valid` = 1.
  - `clear_ovf` also sets `peak` ← 0.
  - If clear and a new sample land on the same edge, `peak` ← that sample.
- Undefined:
  - `peak` is tied to 0 and no peak register is synthesised.
  - All other behaviour is unchanged.

## Test plan
- Reset/fill:
  - Stimulus: assert `reset_n`, release, `enable` = 1, `dry` = 0x11, `wet` = 0x22, `mode` = 01.
  - Required: `valid` = 0 and `out` = 0x11 through the fill; `valid` rises exactly FILL_CYCLES+1 edges after enable is sampled, with `out` = 0x22.
- Echo sum with saturation:
  - Stimulus: RUN, `mode` = 10, `dry` = 0xF0, `wet` = 0x40, `wet_shift` = 0.
  - Required: `out` = 0xFF, `overflow` = 1.
  - Then `wet_shift` = 3 → `out` = 0xF8, `overflow` stays 1.
  - Then pulse `clear_ovf` → `overflow` = 0.
- Average rounding:
  - Stimulus: `mode` = 11 with `dry`/`wet` = 0x03/0x04, then 0xFF/0xFF.
  - Required: `out` = 0x04, then `out` = 0xFF, with no overflow.
- Enable glitch:
  - Stimulus: in RUN, drop `enable` for one cycle.
  - Required: `valid` = 0 and `out` = 0 for the IDLE cycle, followed by a full FILL_CYCLES refill before `valid` returns.
- Set/clear collision:
  - Stimulus: `clear_ovf` = 1 on the same edge as a saturating sum.
  - Required: `overflow` = 1.
- Peak (with `ECHO_MIXER_PEAK_EN`):
  - Stimulus: output sequence 0x10, 0x80, 0x20.
  - Required: `peak` = 0x80; `clear_ovf` while `out` becomes 0x30 → `peak` = 0x30.
  - Without the macro: `peak` stays 0 throughout.
